// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multicycle sequencer: FSM states,
// opcode fields, ALU operation encodings and instruction classes.
package legv8_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEM_REQ,
    MEM_WAIT,
    WRITEBACK,
    TRAP
  } state_e;

  // 11-bit opcodes in ir[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ is identified by ir[31:24], B by ir[31:26]
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // ALU control class handed to the datapath's ALU control unit
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational instruction classifier for the LEGv8 subset.
module opcode_decoder
  import legv8_pkg::*;
(
  input  logic [31:0]  ir_i,
  output instr_class_e cls_o
);

  // Classify the instruction: 11-bit opcodes first, then CBZ, then B.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path can leave it unassigned and infer a latch.
    cls_o = CLS_ILLEGAL;
    unique case (ir_i[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: cls_o = CLS_RTYPE;
      OP_LDUR:                        cls_o = CLS_LDUR;
      OP_STUR:                        cls_o = CLS_STUR;
      default: begin
        if (ir_i[31:24] == OP_CBZ) begin
          cls_o = CLS_CBZ;
        end else if (ir_i[31:26] == OP_B) begin
          cls_o = CLS_B;
        end
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle LEGv8 control sequencer: fetches over a valid/ready instruction
// channel, decodes, steers the external datapath, issues loads/stores over a
// valid/ready data channel and advances the PC. Illegal encodings lock the
// sequencer in TRAP until reset.
// Optional build macro: PERF_COUNTERS_EN adds cycle_count and instr_count.
// dmem_addr is taken from the low bits of alu_result, so DATA_WIDTH must be
// at least ADDR_WIDTH.
module multicycle_sequencer
  import legv8_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  // instruction request / response
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  // data request / response
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_data,
  // datapath inputs
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] store_data,
  // datapath controls
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           ir,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  alu_src,
  output logic                  reg2loc,
  output logic [1:0]            alu_op,
  output logic [DATA_WIDTH-1:0] load_data,
  // status
  output logic                  instr_retired,
`ifdef PERF_COUNTERS_EN
  output logic [63:0]           cycle_count,
  output logic [63:0]           instr_count,
`endif
  output logic                  trap
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  instr_class_e          cls;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  // Raw (pre-reset-gating) request and strobe values
  logic imem_req_valid_c, dmem_req_valid_c, dmem_write_c;
  logic reg_write_c, mem_to_reg_c, retire_c;

  opcode_decoder u_opcode_decoder (
    .ir_i  (ir_q),
    .cls_o (cls)
  );

  // Modulo-2^ADDR_WIDTH increment; the carry out is simply dropped.
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  // State, PC, IR and load-data registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= FETCH_REQ;
      pc_q        <= PC_RESET;
      ir_q        <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      load_data_q <= load_data_d;
    end
  end

  // Next-state and control decode; outputs are Moore-style off state_q so
  // requests stay stable while waiting for ready.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ir_d             = ir_q;
    load_data_d      = load_data_q;
    imem_req_valid_c = 1'b0;
    dmem_req_valid_c = 1'b0;
    dmem_write_c     = 1'b0;
    reg_write_c      = 1'b0;
    mem_to_reg_c     = 1'b0;
    retire_c         = 1'b0;
    alu_src          = 1'b0;
    reg2loc          = 1'b0;
    alu_op           = ALUOP_MEM;

    unique case (state_q)
      FETCH_REQ: begin
        imem_req_valid_c = 1'b1;
        if (imem_req_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = (cls == CLS_ILLEGAL) ? TRAP : EXECUTE;
      end
      EXECUTE: begin
        unique case (cls)
          CLS_RTYPE: begin
            alu_op  = ALUOP_RTYPE;
            state_d = WRITEBACK;
          end
          CLS_LDUR: begin
            alu_src = 1'b1;
            state_d = MEM_REQ;
          end
          CLS_STUR: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
            state_d = MEM_REQ;
          end
          CLS_CBZ: begin
            alu_op   = ALUOP_BRANCH;
            reg2loc  = 1'b1;
            pc_d     = alu_zero ? branch_target : pc_plus4;
            retire_c = 1'b1;
            state_d  = FETCH_REQ;
          end
          CLS_B: begin
            pc_d     = branch_target;
            retire_c = 1'b1;
            state_d  = FETCH_REQ;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM_REQ: begin
        // Keep the address/store-data controls asserted so alu_result and
        // store_data stay valid for the whole request.
        alu_src          = 1'b1;
        reg2loc          = (cls == CLS_STUR);
        dmem_req_valid_c = 1'b1;
        dmem_write_c     = (cls == CLS_STUR);
        if (dmem_req_ready) begin
          // Stores finish in WRITEBACK (PC advance, no register write).
          state_d = (cls == CLS_STUR) ? WRITEBACK : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          load_data_d = dmem_rsp_data;
          state_d     = WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_write_c  = (cls != CLS_STUR);
        mem_to_reg_c = (cls == CLS_LDUR);
        pc_d         = pc_plus4;
        retire_c     = 1'b1;
        state_d      = FETCH_REQ;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = TRAP;
    endcase
  end

  // Requests and strobes drop in the same cycle reset is raised.
  assign imem_req_valid = imem_req_valid_c & ~reset;
  assign dmem_req_valid = dmem_req_valid_c & ~reset;
  assign dmem_write     = dmem_write_c & ~reset;
  assign reg_write      = reg_write_c & ~reset;
  assign mem_to_reg     = mem_to_reg_c & ~reset;
  assign instr_retired  = retire_c & ~reset;
  assign trap           = (state_q == TRAP) & ~reset;

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_result[ADDR_WIDTH-1:0];
  assign dmem_wdata = store_data;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign load_data  = load_data_q;

`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_count_q, instr_count_q;

  // Free-running cycle and retirement counters, wrapping at 2^64.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_q + 64'd1;
      if (retire_c) instr_count_q <= instr_count_q + 64'd1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a vector table of single
// instructions run from reset, plus hand-written multi-cycle sequences
// (stalls, delayed load response, PC wrap, trap, reset mid-transaction).
`timescale 1ns/1ps
module tb_multicycle_sequencer;
  import legv8_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  localparam logic [DW-1:0] ALU_RES    = 64'h0000_0000_0000_1238;
  localparam logic [DW-1:0] STORE_DATA = 64'h5555_AAAA_0123_4567;
  localparam logic [DW-1:0] LOAD_WORD  = 64'hCAFE_F00D_1234_5678;
  localparam logic [DW-1:0] LATE_WORD  = 64'hDEAD_BEEF_DEAD_BEEF;

  localparam logic [31:0] I_ADD  = {11'b10001011000, 21'h00123};
  localparam logic [31:0] I_SUB  = {11'b11001011000, 21'h00123};
  localparam logic [31:0] I_AND  = {11'b10001010000, 21'h00123};
  localparam logic [31:0] I_ORR  = {11'b10101010000, 21'h00123};
  localparam logic [31:0] I_LDUR = {11'b11111000010, 21'h00041};
  localparam logic [31:0] I_STUR = {11'b11111000000, 21'h00041};
  localparam logic [31:0] I_CBZ  = {8'b10110100, 24'h000060};
  localparam logic [31:0] I_B    = {6'b000101, 26'h0000010};
  localparam logic [31:0] I_BAD1 = {11'b10001011001, 21'h00000};
  localparam logic [31:0] I_BAD2 = 32'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          dmem_req_valid, dmem_req_ready, dmem_write;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_rsp_valid;
  logic [DW-1:0] dmem_rsp_data;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic [AW-1:0] branch_target;
  logic [DW-1:0] store_data;
  logic [AW-1:0] pc;
  logic [31:0]   ir;
  logic          reg_write, mem_to_reg, alu_src, reg2loc;
  logic [1:0]    alu_op;
  logic [DW-1:0] load_data;
  logic          instr_retired, trap;
`ifdef PERF_COUNTERS_EN
  logic [63:0]   cycle_count, instr_count;
`endif

  always #5 clock = ~clock;

  multicycle_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PC_RESET   ('0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_write     (dmem_write),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .branch_target  (branch_target),
    .store_data     (store_data),
    .pc             (pc),
    .ir             (ir),
    .reg_write      (reg_write),
    .mem_to_reg     (mem_to_reg),
    .alu_src        (alu_src),
    .reg2loc        (reg2loc),
    .alu_op         (alu_op),
    .load_data      (load_data),
    .instr_retired  (instr_retired),
`ifdef PERF_COUNTERS_EN
    .cycle_count    (cycle_count),
    .instr_count    (instr_count),
`endif
    .trap           (trap)
  );

  int checks = 0;
  int errors = 0;

  // Memory-model state
  logic [31:0]   cur_instr;
  logic [AW-1:0] exp_fetch;
  logic          imem_wait, dmem_wait;
  int            dmem_cnt, dmem_delay, imem_stall, dmem_stall, late_left;

  // Per-cycle samples and per-instruction results
  logic       s_ret, s_rw, s_m2r, s_asrc, s_r2l, s_dv, s_dw, s_trap, s_iv;
  logic [1:0] s_aop;
  int         r_cycles, r_rw;
  logic       r_m2r, r_asrc, r_r2l, r_wr, r_trap;
  logic [1:0] r_aop;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic [63:0] target;
    int          cyc;
    int          rw;
    logic        m2r;
    logic [1:0]  aop;
    logic        asrc;
    logic        r2l;
    logic        wr;
    logic        trp;
    logic [63:0] pc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, then drive the
  // memory-model inputs for the coming rising edge.
  task automatic step();
    @(negedge clock);
    s_ret = instr_retired; s_rw = reg_write; s_m2r = mem_to_reg;
    s_aop = alu_op; s_asrc = alu_src; s_r2l = reg2loc;
    s_dv = dmem_req_valid; s_dw = dmem_write; s_trap = trap; s_iv = imem_req_valid;

    // instruction channel: respond the cycle after acceptance
    imem_rsp_valid = 1'b0;
    if (imem_wait) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = cur_instr;
      imem_wait      = 1'b0;
    end
    if (s_iv) begin
      check("imem_addr", imem_addr, exp_fetch);
      if (imem_stall > 0) begin
        imem_req_ready = 1'b0;
        imem_stall--;
      end else begin
        imem_req_ready = 1'b1;
        imem_wait      = 1'b1;
      end
    end else begin
      imem_req_ready = 1'b1;
    end

    // data channel
    dmem_rsp_valid = 1'b0;
    if (late_left > 0) begin
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = LATE_WORD;
      late_left--;
    end
    if (dmem_wait) begin
      if (dmem_cnt == 0) begin
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = LOAD_WORD;
        dmem_wait      = 1'b0;
      end else begin
        dmem_cnt--;
      end
    end
    if (s_dv) begin
      check("dmem_addr", dmem_addr, ALU_RES);
      if (s_dw) check("dmem_wdata", dmem_wdata, STORE_DATA);
      if (dmem_stall > 0) begin
        dmem_req_ready = 1'b0;
        dmem_stall--;
      end else begin
        dmem_req_ready = 1'b1;
        if (!s_dw) begin
          dmem_wait = 1'b1;
          dmem_cnt  = dmem_delay;
        end
      end
    end else begin
      dmem_req_ready = 1'b1;
    end
  endtask

  task automatic clear_model();
    imem_wait = 1'b0; dmem_wait = 1'b0; dmem_cnt = 0;
    imem_stall = 0; dmem_stall = 0; dmem_delay = 0; late_left = 0;
    imem_rsp_valid = 1'b0; dmem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
  endtask

  // Hold reset over two rising edges, check the reset state, release just
  // after a rising edge so the next cycle is cycle 1.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_strobes",
          {63'd0, imem_req_valid | dmem_req_valid | dmem_write | reg_write |
                  mem_to_reg | instr_retired | trap}, 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_ir", {32'd0, ir}, 64'd0);
    check("rst_load_data", load_data, 64'd0);
    reset = 1'b0;
  endtask

  // Run until retire or trap (bounded); cycle 1 is the first FETCH_REQ cycle.
  task automatic run_one(input logic [31:0] instr, input logic [AW-1:0] fetch_pc);
    bit done = 1'b0;
    cur_instr = instr; exp_fetch = fetch_pc;
    r_cycles = 0; r_rw = 0; r_m2r = 1'b0; r_aop = 2'b11;
    r_asrc = 1'bx; r_r2l = 1'bx; r_wr = 1'b0; r_trap = 1'b0;
    while (!done && r_cycles < 60) begin
      step();
      r_cycles++;
      if (s_rw) begin
        r_rw++;
        if (s_m2r) r_m2r = 1'b1;
      end
      if (r_cycles == 4) begin
        r_aop = s_aop; r_asrc = s_asrc; r_r2l = s_r2l;
      end
      if (s_dv && s_dw) r_wr = 1'b1;
      if (s_ret) done = 1'b1;
      if (s_trap) begin
        r_trap = 1'b1;
        done   = 1'b1;
      end
    end
    check("run_timeout", {63'd0, done}, 64'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    alu_result = ALU_RES; store_data = STORE_DATA;
    alu_zero = 1'b0; branch_target = '0;
    imem_rsp_data = '0; dmem_rsp_data = '0;
    cur_instr = '0; exp_fetch = '0;
    clear_model();

    //          name         instr   z     target  cyc rw m2r aop    asrc r2l wr  trp pc
    vecs[0]  = '{"add",      I_ADD,  1'b0, 64'h0,  5, 1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4};
    vecs[1]  = '{"sub",      I_SUB,  1'b0, 64'h0,  5, 1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4};
    vecs[2]  = '{"and",      I_AND,  1'b0, 64'h0,  5, 1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4};
    vecs[3]  = '{"orr",      I_ORR,  1'b0, 64'h0,  5, 1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4};
    vecs[4]  = '{"ldur",     I_LDUR, 1'b0, 64'h0,  7, 1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4};
    vecs[5]  = '{"stur",     I_STUR, 1'b0, 64'h0,  6, 0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 64'h4};
    vecs[6]  = '{"cbz_take", I_CBZ,  1'b1, 64'h40, 4, 0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 64'h40};
    vecs[7]  = '{"cbz_fall", I_CBZ,  1'b0, 64'h40, 4, 0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 64'h4};
    vecs[8]  = '{"b",        I_B,    1'b0, 64'h100,4, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 64'h100};
    vecs[9]  = '{"bad_add",  I_BAD1, 1'b0, 64'h0,  4, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
    vecs[10] = '{"bad_zero", 32'h0,  1'b0, 64'h0,  4, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};

    // Table: each instruction from reset with zero-wait memories
    for (int i = 0; i < 11; i++) begin
      do_reset();
      alu_zero = vecs[i].zero;
      branch_target = vecs[i].target;
      run_one(vecs[i].instr, 64'h0);
      check({vecs[i].name, "_cycles"}, 64'(r_cycles), 64'(vecs[i].cyc));
      check({vecs[i].name, "_regwr"}, 64'(r_rw), 64'(vecs[i].rw));
      check({vecs[i].name, "_m2r"}, {63'd0, r_m2r}, {63'd0, vecs[i].m2r});
      check({vecs[i].name, "_ctl"}, {60'd0, r_aop, r_asrc, r_r2l},
            {60'd0, vecs[i].aop, vecs[i].asrc, vecs[i].r2l});
      check({vecs[i].name, "_store"}, {63'd0, r_wr}, {63'd0, vecs[i].wr});
      check({vecs[i].name, "_trap"}, {63'd0, r_trap}, {63'd0, vecs[i].trp});
      check({vecs[i].name, "_pc"}, pc, vecs[i].pc);
      check({vecs[i].name, "_ir"}, {32'd0, ir}, {32'd0, vecs[i].instr});
    end

    // Taken CBZ followed by ADD: next fetch comes from the branch target
    do_reset();
    alu_zero = 1'b1; branch_target = 64'h40;
    run_one(I_CBZ, 64'h0);
    alu_zero = 1'b0;
    run_one(I_ADD, 64'h40);
    check("seq_add_cycles", 64'(r_cycles), 64'd5);
    check("seq_add_pc", pc, 64'h44);

    // LDUR with the load response three cycles late
    do_reset();
    dmem_delay = 3;
    run_one(I_LDUR, 64'h0);
    check("ldur_slow_cycles", 64'(r_cycles), 64'd10);
    check("ldur_slow_m2r", {63'd0, r_m2r}, 64'd1);
    check("ldur_slow_data", load_data, LOAD_WORD);
    check("ldur_slow_pc", pc, 64'h4);

    // STUR with data-channel ready held low for three cycles
    do_reset();
    dmem_stall = 3;
    run_one(I_STUR, 64'h0);
    check("stur_stall_cycles", 64'(r_cycles), 64'd9);
    check("stur_stall_write", {63'd0, r_wr}, 64'd1);

    // ADD with fetch ready held low for two cycles
    do_reset();
    imem_stall = 2;
    run_one(I_ADD, 64'h0);
    check("fetch_stall_cycles", 64'(r_cycles), 64'd7);
    check("fetch_stall_pc", pc, 64'h4);

    // PC wrap: branch to the top word, then ADD wraps to 0
    do_reset();
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    run_one(I_B, 64'h0);
    check("wrap_b_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_target = 64'h0;
    run_one(I_ADD, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_add_cycles", 64'(r_cycles), 64'd5);
    check("wrap_add_pc", pc, 64'h0);

    // Trap on all-ones word: sticky, no further fetches until reset
    do_reset();
    run_one(I_BAD2, 64'h0);
    check("trap_seen", {63'd0, r_trap}, 64'd1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_iv || s_dv || s_rw || s_ret || !s_trap) bad++;
    end
    check("trap_hold", 64'(bad), 64'd0);
    do_reset();
    run_one(I_ADD, 64'h0);
    check("trap_recover_pc", pc, 64'h4);

    // Reset during a stalled data request drops the request at once
    do_reset();
    cur_instr = I_STUR; exp_fetch = 64'h0; dmem_stall = 10;
    for (int c = 0; c < 6; c++) step();
    check("mreq_pending", {63'd0, s_dv}, 64'd1);
    reset = 1'b1;
    #1;
    check("mreq_drop", {63'd0, dmem_req_valid}, 64'd0);

    // Reset during MEM_WAIT, then a late load response is ignored
    do_reset();
    cur_instr = I_LDUR; exp_fetch = 64'h0; dmem_delay = 20;
    for (int c = 0; c < 7; c++) step();
    check("mwait_no_retire", {63'd0, s_ret | s_dv}, 64'd0);
    do_reset();
    late_left = 2;
    run_one(I_ADD, 64'h0);
    check("late_rsp_cycles", 64'(r_cycles), 64'd5);
    check("late_rsp_load", load_data, 64'd0);
    check("late_rsp_pc", pc, 64'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
